// File: rtl/snake_pkg.sv
// Shared Snake playfield geometry and the food spawner state encoding.
// Used by the game FSM, the renderer and the spawner.
package snake_pkg;

    localparam int unsigned GRID_W   = 40;
    localparam int unsigned GRID_H   = 30;
    localparam int unsigned X_BITS   = 6;
    localparam int unsigned Y_BITS   = 5;
    localparam int unsigned RND_BITS = 15;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRnd,
        StCheck,
        StWaitOcc,
        StSweepRd,
        StSweepChk,
        StDone,
        StFull
    } spawn_state_e;

endpackage

// File: rtl/food_spawner_if.sv
// Signals between the food spawner, the game FSM, the RNG and the occupancy RAM.
// slave is the spawner side; master is the surrounding game logic.
interface food_spawner_if #(
    parameter int unsigned X_BITS = snake_pkg::X_BITS,
    parameter int unsigned Y_BITS = snake_pkg::Y_BITS
);
    logic                           spawn_req;
    logic [snake_pkg::RND_BITS-1:0] rnd;
    logic                           occ_rd;
    logic [X_BITS-1:0]              occ_x;
    logic [Y_BITS-1:0]              occ_y;
    logic                           occ_hit;
    logic [X_BITS-1:0]              food_x;
    logic [Y_BITS-1:0]              food_y;
    logic                           food_valid;
    logic                           food_ack;
    logic                           busy;
    logic                           full;
    logic                           swept;

    modport master (
        output spawn_req, rnd, occ_hit, food_ack,
        input  occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, full, swept
    );

    modport slave (
        input  spawn_req, rnd, occ_hit, food_ack,
        output occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, full, swept
    );

endinterface

// File: rtl/food_spawner.sv
// Places a food item: random candidates from the RNG, range and occupancy checked,
// falling back to a row-major sweep after MAX_TRIES rejections.
module food_spawner #(
    parameter int unsigned GRID_W    = snake_pkg::GRID_W,
    parameter int unsigned GRID_H    = snake_pkg::GRID_H,
    parameter int unsigned X_BITS    = snake_pkg::X_BITS,
    parameter int unsigned Y_BITS    = snake_pkg::Y_BITS,
    parameter int unsigned MAX_TRIES = 8
) (
    input logic           clk,
    input logic           rst,
    food_spawner_if.slave bus
);
    import snake_pkg::*;

    localparam int unsigned TW = $clog2(MAX_TRIES + 1);
    localparam logic [X_BITS-1:0] XLast    = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] YLast    = Y_BITS'(GRID_H - 1);
    localparam logic [TW-1:0]     TriesMax = TW'(MAX_TRIES);

    spawn_state_e      state_q, state_d;
    logic [TW-1:0]     tries_q, tries_d, tries_inc;
    logic [X_BITS-1:0] cand_x_q, cand_x_d, ptr_x_q, ptr_x_d, food_x_q, food_x_d;
    logic [Y_BITS-1:0] cand_y_q, cand_y_d, ptr_y_q, ptr_y_d, food_y_q, food_y_d;
    logic              swept_q, swept_d;
    logic              occ_rd, reject, in_range;

    // Upper RNG bits beyond the coordinate slice are intentionally discarded.
    logic unused_rnd;
    assign unused_rnd = ^(bus.rnd >> (X_BITS + Y_BITS));

    assign tries_inc = tries_q + TW'(1);
    assign in_range  = (cand_x_q <= XLast) && (cand_y_q <= YLast);

    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        ptr_x_d  = ptr_x_q;
        ptr_y_d  = ptr_y_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        swept_d  = swept_q;
        occ_rd   = 1'b0;
        reject   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.spawn_req) begin
                    state_d = StWaitRnd;
                    tries_d = '0;
                end
            end
            StWaitRnd: begin
                if (bus.rnd != '0) begin
                    cand_x_d = bus.rnd[X_BITS-1:0];
                    cand_y_d = bus.rnd[X_BITS+Y_BITS-1:X_BITS];
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (in_range) begin
                    occ_rd  = 1'b1;
                    state_d = StWaitOcc;
                end else begin
                    reject = 1'b1;
                end
            end
            StWaitOcc: begin
                if (!bus.occ_hit) begin
                    food_x_d = cand_x_q;
                    food_y_d = cand_y_q;
                    swept_d  = 1'b0;
                    state_d  = StDone;
                end else begin
                    reject = 1'b1;
                end
            end
            StSweepRd: begin
                occ_rd  = 1'b1;
                state_d = StSweepChk;
            end
            StSweepChk: begin
                if (!bus.occ_hit) begin
                    food_x_d = ptr_x_q;
                    food_y_d = ptr_y_q;
                    swept_d  = 1'b1;
                    state_d  = StDone;
                end else if (ptr_x_q == XLast) begin
                    if (ptr_y_q == YLast) begin
                        state_d = StFull;
                    end else begin
                        ptr_x_d = '0;
                        ptr_y_d = ptr_y_q + Y_BITS'(1);
                        state_d = StSweepRd;
                    end
                end else begin
                    ptr_x_d = ptr_x_q + X_BITS'(1);
                    state_d = StSweepRd;
                end
            end
            StDone: begin
                if (bus.food_ack) begin
                    if (bus.spawn_req) begin
                        state_d = StWaitRnd;
                        tries_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StFull: begin
                if (bus.spawn_req) begin
                    state_d = StWaitRnd;
                    tries_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (reject) begin
            tries_d = tries_inc;
            if (tries_inc == TriesMax) begin
                ptr_x_d = '0;
                ptr_y_d = '0;
                state_d = StSweepRd;
            end else begin
                state_d = StWaitRnd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            tries_q  <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            ptr_x_q  <= '0;
            ptr_y_q  <= '0;
            food_x_q <= '0;
            food_y_q <= '0;
            swept_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            ptr_x_q  <= ptr_x_d;
            ptr_y_q  <= ptr_y_d;
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
            swept_q  <= swept_d;
        end
    end

    // The query address follows the sweep pointer only while a sweep read is issued.
    assign bus.occ_rd     = occ_rd;
    assign bus.occ_x      = (state_q == StSweepRd) ? ptr_x_q : cand_x_q;
    assign bus.occ_y      = (state_q == StSweepRd) ? ptr_y_q : cand_y_q;
    assign bus.food_x     = food_x_q;
    assign bus.food_y     = food_y_q;
    assign bus.swept      = swept_q;
    assign bus.food_valid = (state_q == StDone);
    assign bus.full       = (state_q == StFull);
    assign bus.busy       = !(state_q inside {StIdle, StDone, StFull});

endmodule

// File: doc/food_spawner.md
# food_spawner

Sequences the 15-bit LFSR random-number generator to place a new food item on the Snake playfield. On request it waits for a fresh random sample, slices it into an (x, y) candidate, range-checks it against the grid, and queries the body-occupancy store. It retries up to a limit, then falls back to a deterministic row-major sweep, and presents the result through a valid/ack handshake. It sits between the RNG instance (owned by the parent), the occupancy RAM and the game FSM.

## Interface
- GRID_W, 40, playfield columns
- GRID_H, 30, playfield rows
- X_BITS, 6, x coordinate width
- Y_BITS, 5, y coordinate width
- MAX_TRIES, 8, random candidates attempted before sweep
- Constraint: X_BITS+Y_BITS <= 15; 2^X_BITS >= GRID_W; 2^Y_BITS >= GRID_H

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- spawn_req  in  1  request new food; sampled in IDLE/FULL/DONE only
- rnd  in  15  RNG output; zero except a one-cycle nonzero sample every 16 cycles
- occ_rd  out  1  occupancy read strobe, one cycle
- occ_x  out  X_BITS  occupancy query column
- occ_y  out  Y_BITS  occupancy query row
- occ_hit  in  1  occupancy result, valid the cycle after occ_rd (1 = body present)
- food_x  out  X_BITS  placed food column
- food_y  out  Y_BITS  placed food row
- food_valid  out  1  food position valid; held until food_ack
- food_ack  in  1  consumer accepts food position
- busy  out  1  high in every state except IDLE, DONE, FULL
- full  out  1  no free cell exists; held in FULL
- swept  out  1  last placement came from sweep (valid with food_valid)

## Operation
- States: IDLE, WAIT_RND, CHECK, WAIT_OCC, SWEEP_RD, SWEEP_CHK, DONE, FULL.
- IDLE: spawn_req -> WAIT_RND; tries <= 0.
- WAIT_RND: when rnd != 0, latch cand_x = rnd[X_BITS-1:0], cand_y = rnd[X_BITS+Y_BITS-1:X_BITS]; -> CHECK. rnd == 0 -> stay.
- CHECK: cand_x >= GRID_W or cand_y >= GRID_H -> reject, with no modulo and no clamping. Otherwise drive occ_rd=1 with occ_x/occ_y = candidate; -> WAIT_OCC.
- WAIT_OCC: occ_hit=0 -> latch food_x/y = candidate, swept=0; -> DONE. occ_hit=1 -> reject.
- Reject: tries+1. If the new tries == MAX_TRIES -> SWEEP_RD with sweep pointer (0,0); else -> WAIT_RND.
- SWEEP_RD: occ_rd=1 at the pointer; -> SWEEP_CHK.
- SWEEP_CHK: occ_hit=0 -> food = pointer, swept=1; -> DONE. Otherwise advance the pointer row-major: x+1, wrap to 0 at GRID_W-1 and increment y. Advancing past (GRID_W-1, GRID_H-1) -> FULL; else -> SWEEP_RD.
- DONE: food_valid=1. food_ack -> IDLE; food_ack and spawn_req in the same cycle -> WAIT_RND with tries reset.
- FULL: full=1, food_valid=0. spawn_req -> WAIT_RND with tries reset and full cleared.
- spawn_req while busy is ignored and not queued. food_ack outside DONE is ignored.
- Reset at any point: state IDLE. All outputs and the tries/pointer/candidate registers go to 0, including food_x, food_y, occ_x, occ_y, occ_rd, food_valid, busy, full and swept.

## Timing
- Nonzero rnd at cycle N: candidate registered at the end of N; occ_rd high in N+1; occ_hit sampled in N+2; food_valid high from N+3.
- Out-of-range reject: back in WAIT_RND at N+2. The next sample arrives at N+16, so worst-case random phase is about 16*MAX_TRIES cycles.
- Sweep: 2 cycles per cell. Full-grid worst case is 2*GRID_W*GRID_H cycles, 2400 at the default grid.
- occ_rd is never high two consecutive cycles. occ_x/occ_y are stable while occ_rd=1.
- food_x/y/swept stay stable throughout DONE. food_valid drops the cycle after food_ack.

## Structure
- snake_pkg: GRID_W, GRID_H, X_BITS, Y_BITS, and the spawner state enum. These are shared with the game FSM and renderer.
- Single module, no sub-module. The rng instance stays in the parent, and this block only consumes rnd.

## Test plan
- rnd=15'h0145, occ_hit=0 -> food (5,5), swept=0, food_valid exactly 3 cycles after the sample. Hold it 4 cycles without ack, then ack -> IDLE next cycle.
- rnd=15'h003F (x=63) -> rejected with no occ_rd. Next sample 15'h0145 -> food (5,5) after tries=1.
- occ_hit=1 for all random candidates, MAX_TRIES=8 -> SWEEP starts at (0,0). Occupancy model with only cell (3,0) free -> food (3,0), swept=1.
- Every cell occupied -> full=1 after 2400 sweep cycles, food_valid=0. spawn_req -> full clears, busy=1.
- spawn_req pulsed in CHECK and WAIT_OCC -> ignored. food_ack+spawn_req together in DONE -> WAIT_RND, second placement completes.
- rst low in WAIT_OCC and mid-sweep -> all outputs 0 immediately. After release, spawn_req is needed to restart, and tries starts from 0.
